// File: rtl/serializer_ctrl.sv
// Serial-clock sequencer feeding a WIDTH-bit PISO serializer.
// Buffers upstream words in a small FIFO and issues a one-cycle load strobe
// every WIDTH clocks. When the FIFO is empty at a load, IDLE_WORD is loaded
// instead, so the serial stream never stalls.
// Ports:
//   clk, rst            serial clock; synchronous active-low reset
//   enable              1 = stream, 0 = stop after the current word
//   in_valid/in_ready   upstream handshake; in_data is the upstream word
//   ser_we, ser_data    load strobe and word to the serializer
//   bit_idx             bit position in the current word (0 = load cycle)
//   running             high in RUN and STOP
//   underflow           pulse when IDLE_WORD was loaded
//   underflow_count     saturating underflow counter
module serializer_ctrl #(
    parameter int unsigned      WIDTH     = 10,
    parameter int unsigned      DEPTH     = 4,
    parameter int unsigned      PREFILL   = 2,
    parameter logic [WIDTH-1:0] IDLE_WORD = WIDTH'(10'b1101010100)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     ser_we,
    output logic [WIDTH-1:0]         ser_data,
    output logic [$clog2(WIDTH)-1:0] bit_idx,
    output logic                     running,
    output logic                     underflow,
    output logic [15:0]              underflow_count
);

    localparam int unsigned IDX_W = $clog2(WIDTH);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_STOP
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [WIDTH-1:0]   mem_d [DEPTH];
    logic               in_ready_q, in_ready_d;
    logic               ser_we_q, ser_we_d;
    logic [WIDTH-1:0]   ser_data_q, ser_data_d;
    logic               running_q, running_d;
    logic               underflow_q, underflow_d;
    logic [15:0]        uf_cnt_q, uf_cnt_d;

    logic               last_bit;
    logic               load;
    logic               push;
    logic               pop;

    // Next-state, FIFO bookkeeping and registered-output computation.
    // Outputs are computed from the next state so they line up with the
    // state they describe (a strobe appears in the first RUN cycle).
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        mem_d       = mem_q;
        ser_data_d  = ser_data_q;
        underflow_d = 1'b0;
        uf_cnt_d    = uf_cnt_q;
        last_bit    = (bit_idx_q == IDX_W'(WIDTH - 1));
        push        = in_valid && in_ready_q;

        case (state_q)
            S_IDLE: begin
                bit_idx_d = '0;
                if (enable) state_d = S_FILL;
            end
            S_FILL: begin
                bit_idx_d = '0;
                if (!enable)                          state_d = S_IDLE;
                else if (count_q >= CNT_W'(PREFILL))  state_d = S_RUN;
            end
            S_RUN: begin
                bit_idx_d = last_bit ? '0 : bit_idx_q + IDX_W'(1);
                // A drop on the final bit needs no STOP phase: the word is done.
                if (!enable) state_d = last_bit ? S_IDLE : S_STOP;
            end
            default: begin // S_STOP
                bit_idx_d = last_bit ? '0 : bit_idx_q + IDX_W'(1);
                if (enable)        state_d = S_RUN;
                else if (last_bit) state_d = S_IDLE;
            end
        endcase

        load = (state_d == S_RUN) && (bit_idx_d == '0);
        pop  = load && (count_q != '0);

        // Load decision uses the pre-push count: no bypass at empty.
        if (load) begin
            if (count_q != '0) begin
                ser_data_d = mem_q[rd_ptr_q];
            end else begin
                ser_data_d  = IDLE_WORD;
                underflow_d = 1'b1;
                if (uf_cnt_q != 16'hFFFF) uf_cnt_d = uf_cnt_q + 16'd1;
            end
        end

        if (push) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        ser_we_d   = load;
        in_ready_d = (count_d < CNT_W'(DEPTH));
        running_d  = (state_d == S_RUN) || (state_d == S_STOP);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            bit_idx_q   <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            in_ready_q  <= 1'b0;
            ser_we_q    <= 1'b0;
            ser_data_q  <= '0;
            running_q   <= 1'b0;
            underflow_q <= 1'b0;
            uf_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            mem_q       <= mem_d;
            in_ready_q  <= in_ready_d;
            ser_we_q    <= ser_we_d;
            ser_data_q  <= ser_data_d;
            running_q   <= running_d;
            underflow_q <= underflow_d;
            uf_cnt_q    <= uf_cnt_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign ser_we          = ser_we_q;
    assign ser_data        = ser_data_q;
    assign bit_idx         = bit_idx_q;
    assign running         = running_q;
    assign underflow       = underflow_q;
    assign underflow_count = uf_cnt_q;

endmodule
